// File: rtl/player_move_ctrl.sv
// Tile-based player movement controller: validates each tick-driven step against
// the maze bounds and an external wall map, then hands the redraw to the renderer.
module player_move_ctrl #(
    parameter int GRID_W  = 20,
    parameter int GRID_H  = 15,
    parameter int START_X = 1,
    parameter int START_Y = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] dir,
    input  logic       tick,
    output logic       map_req,
    output logic [8:0] map_addr,
    input  logic       map_ack,
    input  logic       map_wall,
    output logic       draw_req,
    input  logic       draw_ack,
    output logic [4:0] old_x,
    output logic [4:0] old_y,
    output logic [4:0] player_x,
    output logic [4:0] player_y,
    output logic [2:0] heading,
    output logic       busy,
    output logic       blocked,
    output logic [2:0] fsm_state
);

    // Handshakes: a request (map_req / draw_req) stays high with its payload frozen
    // until the matching ack is seen high on a rising edge; it drops the next cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_DRAW   = 3'd4
    } state_t;

    localparam logic [2:0] DIR_STILL = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    localparam logic [5:0] GRID_W6 = 6'(GRID_W);
    localparam logic [5:0] GRID_H6 = 6'(GRID_H);
    localparam logic [8:0] GRID_W9 = 9'(GRID_W);
    localparam logic [4:0] START_X5 = 5'(START_X);
    localparam logic [4:0] START_Y5 = 5'(START_Y);

    state_t     state;
    state_t     state_next;
    logic [2:0] move_dir;
    logic [4:0] tgt_x;
    logic [4:0] tgt_y;

    logic [5:0] tx_c;
    logic [5:0] ty_c;
    logic       in_range;
    logic [8:0] addr_c;

    logic       capture;
    logic       issue;
    logic       do_update;
    logic       reject;
    logic       dir_valid;

    assign dir_valid = (dir >= DIR_UP) && (dir <= DIR_RIGHT);

    // Target is formed one bit wider so that 0-1 wraps to 63 and fails the range test.
    always_comb begin
        tx_c = {1'b0, player_x};
        ty_c = {1'b0, player_y};
        case (move_dir)
            DIR_UP:    ty_c = {1'b0, player_y} - 6'd1;
            DIR_DOWN:  ty_c = {1'b0, player_y} + 6'd1;
            DIR_LEFT:  tx_c = {1'b0, player_x} - 6'd1;
            DIR_RIGHT: tx_c = {1'b0, player_x} + 6'd1;
            default: ;
        endcase
        in_range = (tx_c < GRID_W6) && (ty_c < GRID_H6);
        addr_c   = ({4'b0, ty_c[4:0]} * GRID_W9) + {4'b0, tx_c[4:0]};
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        issue      = 1'b0;
        do_update  = 1'b0;
        reject     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && enable && (heading != DIR_STILL)) begin
                    capture    = 1'b1;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (in_range) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    reject     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (map_ack) begin
                    if (map_wall) begin
                        reject     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                do_update  = 1'b1;
                state_next = S_DRAW;
            end
            S_DRAW: begin
                if (draw_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rejected move clears heading even if a new direction arrives in that same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            heading <= DIR_STILL;
            blocked <= 1'b0;
        end else begin
            blocked <= reject;
            if (reject) begin
                heading <= DIR_STILL;
            end else if (dir_valid) begin
                heading <= dir;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            move_dir <= DIR_STILL;
            tgt_x    <= START_X5;
            tgt_y    <= START_Y5;
            map_addr <= 9'd0;
        end else begin
            if (capture) begin
                move_dir <= heading;
            end
            if (issue) begin
                tgt_x    <= tx_c[4:0];
                tgt_y    <= ty_c[4:0];
                map_addr <= addr_c;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            player_x <= START_X5;
            player_y <= START_Y5;
            old_x    <= START_X5;
            old_y    <= START_Y5;
        end else if (do_update) begin
            old_x    <= player_x;
            old_y    <= player_y;
            player_x <= tgt_x;
            player_y <= tgt_y;
        end
    end

    assign map_req   = (state == S_WAIT);
    assign draw_req  = (state == S_DRAW);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameter GRID_W, default 20, maze width in tiles.
REQ-002 Parameter GRID_H, default 15, maze height in tiles.
REQ-003 Parameter START_X, default 1, reset column; START_Y, default 1, reset row.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  accept move ticks when high.
REQ-007 dir  in  3  keyboard direction code: 000 still, 001 up, 010 left, 011 down, 100 right.
REQ-008 tick  in  1  single-cycle move-rate pulse.
REQ-009 map_req  out  1  wall-map read request.
REQ-010 map_addr  out  9  wall-map tile address, valid while map_req is high.
REQ-011 map_ack  in  1  read complete; map_wall valid in the same cycle.
REQ-012 map_wall  in  1  1 = addressed tile is a wall.
REQ-013 draw_req  out  1  redraw request to the renderer.
REQ-014 draw_ack  in  1  renderer accepted the redraw.
REQ-015 old_x, old_y  out  5 each  previous position, valid while draw_req is high.
REQ-016 player_x, player_y  out  5 each  current tile position.
REQ-017 heading  out  3  latched direction, using the dir encoding.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 blocked  out  1  one-cycle pulse when a move is rejected.

Function
REQ-020 FSM states SHALL be IDLE, CHECK, WAIT, UPDATE and DRAW.
REQ-021 heading SHALL load dir in any cycle where dir is 001–100, in any state; 000 and 101–111 leave heading unchanged.
REQ-022 IDLE -> CHECK SHALL occur on tick & enable & heading != 000; ticks are dropped in all other conditions, including ticks in non-IDLE states.
REQ-023 CHECK SHALL compute the target tile from the position and the heading captured on entry: up y-1, down y+1, left x-1, right x+1.
REQ-024 If the target is outside 0..GRID_W-1 or 0..GRID_H-1, CHECK SHALL pulse blocked, clear heading to 000, return to IDLE, and SHALL NOT assert map_req.
REQ-025 Otherwise CHECK SHALL assert map_req with map_addr = ty*GRID_W + tx, then go to WAIT.
REQ-026 map_req and map_addr SHALL be held stable in WAIT until the cycle map_ack=1; map_req SHALL drop in the following cycle.
REQ-027 In the map_ack cycle, map_wall=1 SHALL pulse blocked, clear heading to 000 and go to IDLE; map_wall=0 SHALL go to UPDATE.
REQ-028 UPDATE SHALL copy player_x/y to old_x/y, load the target into player_x/y, and go to DRAW; this takes one cycle.
REQ-029 DRAW SHALL hold draw_req=1 with old_x/y and player_x/y stable until draw_ack=1, then return to IDLE in the next cycle.
REQ-030 Latency, tick to position change with a 1-cycle map_ack: 4 cycles (CHECK, WAIT, UPDATE, then player_x/y valid).
REQ-031 enable falling SHALL NOT abort an in-flight move; it only gates new ticks in IDLE.
REQ-032 draw_ack or map_ack asserted outside DRAW or WAIT respectively SHALL be ignored.
REQ-033 A dir change during CHECK/WAIT/UPDATE/DRAW SHALL update heading only; the in-flight target is unaffected.

Reset
REQ-034 reset SHALL asynchronously set: state IDLE, player_x=old_x=START_X, player_y=old_y=START_Y, heading=000, map_req=0, map_addr=0, draw_req=0, blocked=0, busy=0.
REQ-035 reset mid-transaction SHALL abandon the transaction without a blocked pulse; after reset is released, a late map_ack or draw_ack SHALL be ignored.

Verification
REQ-036 After reset: dir=100, tick, map_ack one cycle later with wall=0 -> map_addr=22, player_x=2, player_y=1, draw_req held until draw_ack, with old_x=1.
REQ-037 Position (1,1), dir=001, tick, map_ack with wall=1 -> blocked pulses once, heading=000, position unchanged, draw_req never asserted.
REQ-038 Position (0,5), dir=010, tick -> blocked pulses with map_req never asserted; a later tick with heading=000 is ignored.
REQ-039 Two ticks 2 cycles apart, map_ack delayed 10 cycles -> exactly one move; the second tick is dropped; busy is high for the entire move.
REQ-040 reset asserted in WAIT, then map_ack after release -> outputs at reset values, no state change from the late ack.
REQ-041 enable=0 with ticks and heading=011 -> no map_req; enable=1 plus a tick -> a move down proceeds normally.
